// File: rtl/regfile_multiport.sv
// Multi-port register file with per-byte writes, optional hardwired zero register,
// write-to-read bypass and a per-register busy scoreboard for hazard detection.
module regfile_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          w_addr,
  input  logic [DATA_WIDTH-1:0]          w_data,
  input  logic [DATA_WIDTH/8-1:0]        w_be,
  input  logic                           busy_set,
  input  logic [ADDR_WIDTH-1:0]          busy_addr,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] r_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] r_data,
  output logic [NUM_READ-1:0]            r_busy
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int NUM_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DATA_WIDTH-1:0] be_mask;
  logic                  w_allowed;
  logic                  b_allowed;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_be_mask
      assign be_mask[gi*8 +: 8] = {8{w_be[gi]}};
    end
  endgenerate

  // Register 0 is frozen when it is the hardwired zero register.
  assign w_allowed = wr_en    && !((ZERO_REG != 0) && (w_addr == '0));
  assign b_allowed = busy_set && !((ZERO_REG != 0) && (busy_addr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (w_allowed) begin
      regs[w_addr] <= (regs[w_addr] & ~be_mask) | (w_data & be_mask);
    end
  end

  // A new producer supersedes a completing one: set has priority over clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (b_allowed && (busy_addr == ADDR_WIDTH'(i))) begin
          busy[i] <= 1'b1;
        end else if (w_allowed && (w_addr == ADDR_WIDTH'(i))) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_read
      logic [ADDR_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0] stored;
      logic [DATA_WIDTH-1:0] merged;
      logic [DATA_WIDTH-1:0] rd;
      logic                  rb;
      logic                  hit;
      logic                  is_zero;

      assign ra      = r_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign stored  = regs[ra];
      assign merged  = (stored & ~be_mask) | (w_data & be_mask);
      assign hit     = (BYPASS != 0) && wr_en && (w_addr == ra);
      assign is_zero = (ZERO_REG != 0) && (ra == '0);

      // Outputs are forced to zero during reset so an in-flight write cannot leak through the bypass.
      always_comb begin
        rd = '0;
        rb = 1'b0;
        if (!rst && !is_zero) begin
          if (hit) begin
            rd = merged;
          end else begin
            rd = stored;
            rb = busy[ra];
          end
        end
      end

      assign r_data[gi*DATA_WIDTH +: DATA_WIDTH] = rd;
      assign r_busy[gi]                          = rb;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport: a behavioural model feeds a scoreboard of expected
// read results that is compared against the DUT once the combinational reads have settled.
module tb_regfile_multiport;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [3:0]  w_be;
  logic        busy_set;
  logic [4:0]  busy_addr;
  logic [9:0]  r_addr;
  logic [63:0] r_data_a;
  logic [1:0]  r_busy_a;
  logic [63:0] r_data_b;
  logic [1:0]  r_busy_b;

  logic         wr_en4;
  logic [4:0]   w_addr4;
  logic [63:0]  w_data4;
  logic [7:0]   w_be4;
  logic         busy_set4;
  logic [4:0]   busy_addr4;
  logic [19:0]  r_addr4;
  logic [255:0] r_data4;
  logic [3:0]   r_busy4;

  always #5 clk = ~clk;

  regfile_multiport #(.BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data), .w_be(w_be),
    .busy_set(busy_set), .busy_addr(busy_addr), .r_addr(r_addr), .r_data(r_data_a), .r_busy(r_busy_a)
  );

  regfile_multiport #(.BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data), .w_be(w_be),
    .busy_set(busy_set), .busy_addr(busy_addr), .r_addr(r_addr), .r_data(r_data_b), .r_busy(r_busy_b)
  );

  regfile_multiport #(.DATA_WIDTH(64), .NUM_READ(4)) dut_w (
    .clk(clk), .rst(rst), .wr_en(wr_en4), .w_addr(w_addr4), .w_data(w_data4), .w_be(w_be4),
    .busy_set(busy_set4), .busy_addr(busy_addr4), .r_addr(r_addr4), .r_data(r_data4), .r_busy(r_busy4)
  );

  typedef struct {
    string       name;
    int          inst;
    int          port;
    logic [63:0] d;
    logic        b;
  } ent_t;

  ent_t exp_q[$];
  ent_t act_q[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] m_reg  [32];
  logic        m_busy [32];

  task automatic idle();
    wr_en = 1'b0; w_addr = '0; w_data = '0; w_be = '0; busy_set = 1'b0; busy_addr = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Advance one clock edge and apply the same edge to the model using the held inputs.
  task automatic step();
    @(posedge clk);
    if (!rst) begin
      if (wr_en && w_addr != 5'd0) begin
        for (int b = 0; b < 4; b++) if (w_be[b]) m_reg[w_addr][b*8 +: 8] = w_data[b*8 +: 8];
        m_busy[w_addr] = 1'b0;
      end
      if (busy_set && busy_addr != 5'd0) m_busy[busy_addr] = 1'b1;
    end
    #1;
  endtask

  function automatic logic [31:0] exp_data(logic [4:0] a, bit byp);
    logic [31:0] v;
    if (rst || a == 5'd0) return 32'd0;
    v = m_reg[a];
    if (byp && wr_en && w_addr == a)
      for (int b = 0; b < 4; b++) if (w_be[b]) v[b*8 +: 8] = w_data[b*8 +: 8];
    return v;
  endfunction

  function automatic logic exp_busy(logic [4:0] a, bit byp);
    if (rst || a == 5'd0) return 1'b0;
    if (byp && wr_en && w_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  // Push model expectations for both 32-bit instances, then capture what they produce.
  task automatic sample(string name);
    ent_t e;
    for (int k = 0; k < 2; k++) begin
      e.name = name; e.port = k;
      e.inst = 0; e.d = {32'd0, exp_data(r_addr[k*5 +: 5], 1'b1)}; e.b = exp_busy(r_addr[k*5 +: 5], 1'b1);
      exp_q.push_back(e);
      e.inst = 1; e.d = {32'd0, exp_data(r_addr[k*5 +: 5], 1'b0)}; e.b = exp_busy(r_addr[k*5 +: 5], 1'b0);
      exp_q.push_back(e);
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      e.name = name; e.port = k;
      e.inst = 0; e.d = {32'd0, r_data_a[k*32 +: 32]}; e.b = r_busy_a[k];
      act_q.push_back(e);
      e.inst = 1; e.d = {32'd0, r_data_b[k*32 +: 32]}; e.b = r_busy_b[k];
      act_q.push_back(e);
    end
  endtask

  task automatic do_write(logic [4:0] a, logic [31:0] d, logic [3:0] be);
    wr_en = 1'b1; w_addr = a; w_data = d; w_be = be;
    step();
    idle();
  endtask

  task automatic test_reset();
    ent_t e, a;
    rst = 1'b1;
    model_reset();
    r_addr = {5'd5, 5'd1};
    step();
    sample("reset_hold");
    rst = 1'b0;
    do_write(5'd5, 32'hDEADBEEF, 4'hF);
    busy_set = 1'b1; busy_addr = 5'd1;
    step();
    idle();
    sample("pre_reset");
    wr_en = 1'b1; w_addr = 5'd5; w_data = 32'h12345678; w_be = 4'hF;
    rst = 1'b1;
    model_reset();
    sample("reset_async");
    step();
    rst = 1'b0;
    idle();
    step();
    sample("after_reset");
    checks++;
    if (r_data_a[63:32] !== 32'd0) begin
      errors++;
      $display("FAIL reset_reg5 r_data got %h expected %h", r_data_a[63:32], 32'd0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a.d !== e.d) begin errors++; $display("FAIL %s inst%0d port%0d r_data got %h expected %h", e.name, e.inst, e.port, a.d, e.d); end
      checks++;
      if (a.b !== e.b) begin errors++; $display("FAIL %s inst%0d port%0d r_busy got %b expected %b", e.name, e.inst, e.port, a.b, e.b); end
    end
  endtask

  task automatic test_write();
    ent_t e, a;
    do_write(5'd1, 32'd25, 4'hF);
    do_write(5'd2, 32'd50, 4'hF);
    do_write(5'd0, 32'd77, 4'hF);
    r_addr = {5'd2, 5'd1};
    sample("read_1_2");
    checks++;
    if (r_data_a !== {32'd50, 32'd25}) begin
      errors++;
      $display("FAIL read_1_2_const r_data got %h expected %h", r_data_a, {32'd50, 32'd25});
    end
    r_addr = {5'd0, 5'd0};
    sample("read_zero");
    do_write(5'd3, 32'h11223344, 4'hF);
    do_write(5'd3, 32'hAABBCCDD, 4'b0101);
    r_addr = {5'd3, 5'd3};
    sample("byte_merge");
    checks++;
    if (r_data_b[31:0] !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL byte_merge_const r_data got %h expected %h", r_data_b[31:0], 32'h11BB33DD);
    end
    busy_set = 1'b1; busy_addr = 5'd3;
    step();
    idle();
    wr_en = 1'b1; w_addr = 5'd3; w_data = 32'hFFFFFFFF; w_be = 4'h0;
    sample("be_zero_pre");
    step();
    idle();
    sample("be_zero_post");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a.d !== e.d) begin errors++; $display("FAIL %s inst%0d port%0d r_data got %h expected %h", e.name, e.inst, e.port, a.d, e.d); end
      checks++;
      if (a.b !== e.b) begin errors++; $display("FAIL %s inst%0d port%0d r_busy got %b expected %b", e.name, e.inst, e.port, a.b, e.b); end
    end
  endtask

  task automatic test_bypass();
    ent_t e, a;
    wr_en = 1'b1; w_addr = 5'd4; w_data = 32'd100; w_be = 4'hF;
    r_addr = {5'd1, 5'd4};
    sample("bypass_pre");
    checks++;
    if (r_data_a[31:0] !== 32'd100) begin
      errors++;
      $display("FAIL bypass_const r_data got %h expected %h", r_data_a[31:0], 32'd100);
    end
    step();
    idle();
    sample("bypass_post");
    wr_en = 1'b1; w_addr = 5'd4; w_data = 32'h0000AB00; w_be = 4'b0010;
    sample("bypass_partial");
    step();
    idle();
    wr_en = 1'b1; w_addr = 5'd0; w_data = 32'hFFFFFFFF; w_be = 4'hF;
    r_addr = {5'd0, 5'd0};
    sample("bypass_zero");
    step();
    idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a.d !== e.d) begin errors++; $display("FAIL %s inst%0d port%0d r_data got %h expected %h", e.name, e.inst, e.port, a.d, e.d); end
      checks++;
      if (a.b !== e.b) begin errors++; $display("FAIL %s inst%0d port%0d r_busy got %b expected %b", e.name, e.inst, e.port, a.b, e.b); end
    end
  endtask

  task automatic test_scoreboard();
    ent_t e, a;
    busy_set = 1'b1; busy_addr = 5'd7;
    r_addr = {5'd7, 5'd7};
    sample("busy_set_same_cycle");
    step();
    idle();
    sample("busy_after_set");
    checks++;
    if (r_busy_a !== 2'b11) begin
      errors++;
      $display("FAIL busy_after_set_const r_busy got %b expected %b", r_busy_a, 2'b11);
    end
    step();
    step();
    busy_set = 1'b1; busy_addr = 5'd7;
    step();
    idle();
    wr_en = 1'b1; w_addr = 5'd7; w_data = 32'h5; w_be = 4'hF;
    sample("busy_write_cycle");
    step();
    idle();
    sample("busy_cleared");
    wr_en = 1'b1; w_addr = 5'd9; w_data = 32'h99; w_be = 4'hF;
    busy_set = 1'b1; busy_addr = 5'd9;
    step();
    idle();
    r_addr = {5'd9, 5'd7};
    sample("busy_set_wins");
    busy_set = 1'b1; busy_addr = 5'd0;
    step();
    idle();
    r_addr = {5'd0, 5'd9};
    sample("busy_zero_reg");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a.d !== e.d) begin errors++; $display("FAIL %s inst%0d port%0d r_data got %h expected %h", e.name, e.inst, e.port, a.d, e.d); end
      checks++;
      if (a.b !== e.b) begin errors++; $display("FAIL %s inst%0d port%0d r_busy got %b expected %b", e.name, e.inst, e.port, a.b, e.b); end
    end
  endtask

  task automatic test_back_to_back();
    ent_t e, a;
    for (int n = 0; n < 40; n++) begin
      wr_en     = 1'($urandom_range(0, 1));
      w_addr    = 5'($urandom_range(0, 7));
      w_data    = $urandom;
      w_be      = 4'($urandom_range(0, 15));
      busy_set  = 1'($urandom_range(0, 1));
      busy_addr = 5'($urandom_range(0, 7));
      r_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      sample("back_to_back");
      step();
    end
    idle();
    sample("back_to_back_idle");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a.d !== e.d) begin errors++; $display("FAIL %s inst%0d port%0d r_data got %h expected %h", e.name, e.inst, e.port, a.d, e.d); end
      checks++;
      if (a.b !== e.b) begin errors++; $display("FAIL %s inst%0d port%0d r_busy got %b expected %b", e.name, e.inst, e.port, a.b, e.b); end
    end
  endtask

  task automatic push_wide(string name, logic [63:0] d0, logic [63:0] d1, logic [63:0] d2, logic [63:0] d3);
    ent_t e;
    logic [63:0] dv [4];
    dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
    for (int k = 0; k < 4; k++) begin
      e.name = name; e.inst = 2; e.port = k; e.d = dv[k]; e.b = 1'b0;
      exp_q.push_back(e);
    end
    #1;
    for (int k = 0; k < 4; k++) begin
      e.name = name; e.inst = 2; e.port = k; e.d = r_data4[k*64 +: 64]; e.b = r_busy4[k];
      act_q.push_back(e);
    end
  endtask

  task automatic test_wide();
    ent_t e, a;
    wr_en4 = 1'b1; w_addr4 = 5'd12; w_data4 = 64'h0123456789ABCDEF; w_be4 = 8'hFF;
    step();
    wr_en4 = 1'b1; w_addr4 = 5'd31; w_data4 = 64'hCAFEF00D12345678; w_be4 = 8'hFF;
    r_addr4 = {5'd12, 5'd31, 5'd31, 5'd0};
    push_wide("wide_bypass", 64'd0, 64'hCAFEF00D12345678, 64'hCAFEF00D12345678, 64'h0123456789ABCDEF);
    checks++;
    if (r_data4[127:64] !== r_data4[191:128]) begin
      errors++;
      $display("FAIL wide_same_reg port1 got %h port2 got %h required equal", r_data4[127:64], r_data4[191:128]);
    end
    step();
    wr_en4 = 1'b1; w_addr4 = 5'd31; w_data4 = 64'hFFFFFFFFFFFFFFFF; w_be4 = 8'h0F;
    push_wide("wide_partial", 64'd0, 64'hCAFEF00DFFFFFFFF, 64'hCAFEF00DFFFFFFFF, 64'h0123456789ABCDEF);
    step();
    wr_en4 = 1'b0; w_be4 = '0;
    push_wide("wide_stored", 64'd0, 64'hCAFEF00DFFFFFFFF, 64'hCAFEF00DFFFFFFFF, 64'h0123456789ABCDEF);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a.d !== e.d) begin errors++; $display("FAIL %s inst%0d port%0d r_data got %h expected %h", e.name, e.inst, e.port, a.d, e.d); end
      checks++;
      if (a.b !== e.b) begin errors++; $display("FAIL %s inst%0d port%0d r_busy got %b expected %b", e.name, e.inst, e.port, a.b, e.b); end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    r_addr = '0;
    wr_en4 = 1'b0; w_addr4 = '0; w_data4 = '0; w_be4 = '0;
    busy_set4 = 1'b0; busy_addr4 = '0; r_addr4 = '0;
    model_reset();
    test_reset();
    test_write();
    test_bypass();
    test_scoreboard();
    test_back_to_back();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
